corevx_ptw: RTL and testbench

- Sv32 hardware page-table walker; sits directly behind corevx_tlb.
- On a TLB miss it walks the two-level page table in memory and returns translation or fault to the core/MMU.
- On success it drives the TLB write port (virtual_address_w / accesstag_w / phys_w + write strobe).
- Reads memory through a simple single-outstanding read interface.

---
 rtl/corevx_sv32_pkg.sv | 25 ++
 rtl/corevx_ptw_if.sv | 26 ++
 rtl/corevx_ptw.sv | 141 ++++++++++++++
 tb/tb_corevx_ptw.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/corevx_sv32_pkg.sv
// Sv32 page-table walker shared definitions: PTE bit positions, geometry and walker states.
package corevx_sv32_pkg;

    localparam int VPN_W   = 20;
    localparam int PPN_W   = 22;
    localparam int PADDR_W = 34;

    localparam int PTE_V = 0;
    localparam int PTE_R = 1;
    localparam int PTE_W = 2;
    localparam int PTE_X = 3;
    localparam int PTE_U = 4;
    localparam int PTE_G = 5;
    localparam int PTE_A = 6;
    localparam int PTE_D = 7;

    localparam logic [1:0] RESP_OKAY = 2'd0;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WALK = 2'd1,
        ST_DONE = 2'd2
    } ptw_state_e;

endpackage

// File: rtl/corevx_ptw_if.sv
// Single-outstanding memory read port used by the walker to fetch PTEs.
interface corevx_ptw_if;

    logic                                 m_transaction;
    logic [corevx_sv32_pkg::PADDR_W-1:0]  m_address;
    logic                                 m_transaction_done;
    logic [1:0]                           m_transaction_response;
    logic [31:0]                          m_rdata;

    modport master (
        output m_transaction,
        output m_address,
        input  m_transaction_done,
        input  m_transaction_response,
        input  m_rdata
    );

    modport slave (
        input  m_transaction,
        input  m_address,
        output m_transaction_done,
        output m_transaction_response,
        output m_rdata
    );

endinterface

// File: rtl/corevx_ptw.sv
// Sv32 two-level page-table walker: resolves a VPN via memory PTE reads and writes the TLB on success.
// Latency 2 cycles (megapage) / 3 cycles (4 KiB) plus memory wait cycles; a read is held until the memory completes it.
module corevx_ptw
    import corevx_sv32_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic [PPN_W-1:0]    satp_ppn,
    input  logic                resolve_request,
    input  logic [VPN_W-1:0]    resolve_virtual_address,
    output logic                busy,
    output logic                resolve_done,
    output logic                resolve_pagefault,
    output logic                resolve_accessfault,
    output logic [7:0]          resolve_access_bits,
    output logic [PPN_W-1:0]    resolve_physical_address,
    output logic                tlb_write,
    output logic [VPN_W-1:0]    tlb_virtual_address_w,
    output logic [7:0]          tlb_accesstag_w,
    output logic [PPN_W-1:0]    tlb_phys_w,
    corevx_ptw_if.master        mem
);

    ptw_state_e         r_state, w_state_nxt;
    logic [VPN_W-1:0]   r_vpn, w_vpn_nxt;
    logic [PPN_W-1:0]   r_base, w_base_nxt;
    logic               r_level, w_level_nxt;
    logic               r_pf, w_pf_nxt;
    logic               r_af, w_af_nxt;
    logic [7:0]         r_acc, w_acc_nxt;
    logic [PPN_W-1:0]   r_phys, w_phys_nxt;

    logic [31:0]        w_pte;
    logic               w_invalid;
    logic               w_leaf;
    logic               w_misaligned;
    logic [PPN_W-1:0]   w_leaf_phys;
    logic               w_unused_rsw;

    // PTE classification of the word returned by the current read.
    always_comb begin
        w_pte        = mem.m_rdata;
        w_invalid    = !w_pte[PTE_V] || (!w_pte[PTE_R] && w_pte[PTE_W]);
        w_leaf       = w_pte[PTE_R] || w_pte[PTE_X];
        w_misaligned = r_level && (w_pte[19:10] != 10'd0);
        w_leaf_phys  = r_level ? {w_pte[31:20], r_vpn[9:0]} : w_pte[31:10];
        w_unused_rsw = ^w_pte[9:8];
    end

    always_comb begin
        w_state_nxt = r_state;
        w_vpn_nxt   = r_vpn;
        w_base_nxt  = r_base;
        w_level_nxt = r_level;
        w_pf_nxt    = r_pf;
        w_af_nxt    = r_af;
        w_acc_nxt   = r_acc;
        w_phys_nxt  = r_phys;
        case (r_state)
            ST_IDLE: begin
                if (resolve_request) begin
                    w_vpn_nxt   = resolve_virtual_address;
                    w_base_nxt  = satp_ppn;
                    w_level_nxt = 1'b1;
                    w_state_nxt = ST_WALK;
                end
            end
            ST_WALK: begin
                if (mem.m_transaction_done) begin
                    w_state_nxt = ST_DONE;
                    w_pf_nxt    = 1'b0;
                    w_af_nxt    = 1'b0;
                    if (mem.m_transaction_response != RESP_OKAY) begin
                        w_af_nxt = 1'b1;
                    end else if (w_invalid) begin
                        w_pf_nxt = 1'b1;
                    end else if (w_leaf) begin
                        if (w_misaligned) begin
                            w_pf_nxt = 1'b1;
                        end else begin
                            w_phys_nxt = w_leaf_phys;
                            w_acc_nxt  = w_pte[7:0];
                        end
                    end else if (!r_level) begin
                        w_pf_nxt = 1'b1;
                    end else begin
                        // Pointer at level 1: descend and issue the level-0 read next cycle.
                        w_base_nxt  = w_pte[31:10];
                        w_level_nxt = 1'b0;
                        w_pf_nxt    = r_pf;
                        w_af_nxt    = r_af;
                        w_state_nxt = ST_WALK;
                    end
                end
            end
            ST_DONE: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_vpn   <= '0;
            r_base  <= '0;
            r_level <= 1'b0;
            r_pf    <= 1'b0;
            r_af    <= 1'b0;
            r_acc   <= '0;
            r_phys  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_vpn   <= w_vpn_nxt;
            r_base  <= w_base_nxt;
            r_level <= w_level_nxt;
            r_pf    <= w_pf_nxt;
            r_af    <= w_af_nxt;
            r_acc   <= w_acc_nxt;
            r_phys  <= w_phys_nxt;
        end
    end

    assign busy                     = (r_state != ST_IDLE);
    assign resolve_done             = (r_state == ST_DONE);
    assign resolve_pagefault        = r_pf;
    assign resolve_accessfault      = r_af;
    assign resolve_access_bits      = r_acc;
    assign resolve_physical_address = r_phys;
    assign tlb_write                = resolve_done && !(r_pf || r_af);
    assign tlb_virtual_address_w    = r_vpn;
    assign tlb_accesstag_w          = r_acc;
    assign tlb_phys_w               = r_phys;

    assign mem.m_transaction = (r_state == ST_WALK);
    assign mem.m_address     = {r_base, (r_level ? r_vpn[19:10] : r_vpn[9:0]), 2'b00};

endmodule

// File: tb/tb_corevx_ptw.sv
// Directed bench for corevx_ptw with a behavioural PTE memory that supports wait states.
module tb_corevx_ptw;

    logic        clk = 1'b0;
    logic        rst;
    logic [21:0] satp_ppn;
    logic        resolve_request;
    logic [19:0] resolve_virtual_address;
    logic        busy, resolve_done, resolve_pagefault, resolve_accessfault, tlb_write;
    logic [7:0]  resolve_access_bits, tlb_accesstag_w;
    logic [21:0] resolve_physical_address, tlb_phys_w;
    logic [19:0] tlb_virtual_address_w;

    corevx_ptw_if mif();

    corevx_ptw dut (
        .clk                      (clk),
        .rst                      (rst),
        .satp_ppn                 (satp_ppn),
        .resolve_request          (resolve_request),
        .resolve_virtual_address  (resolve_virtual_address),
        .busy                     (busy),
        .resolve_done             (resolve_done),
        .resolve_pagefault        (resolve_pagefault),
        .resolve_accessfault      (resolve_accessfault),
        .resolve_access_bits      (resolve_access_bits),
        .resolve_physical_address (resolve_physical_address),
        .tlb_write                (tlb_write),
        .tlb_virtual_address_w    (tlb_virtual_address_w),
        .tlb_accesstag_w          (tlb_accesstag_w),
        .tlb_phys_w               (tlb_phys_w),
        .mem                      (mif.slave)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // Memory model configuration and observation.
    logic [33:0] l1_addr, l0_addr, start_addr;
    logic [31:0] l1_pte, l0_pte;
    logic [1:0]  l1_resp;
    int          wait_n = 0;
    int          wcnt = 0;
    int          nreads = 0;
    int          bad_addr = 0;
    int          unstable = 0;

    // Values captured in the resolve_done cycle.
    logic        c_pf, c_af, c_tw;
    logic [21:0] c_phys, c_tphys;
    logic [7:0]  c_acc, c_tag;
    logic [19:0] c_vaw;
    int          lat, lat2, seen;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        assert (act === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, act, exp);
        end
    endtask

    task automatic setup(input logic [31:0] p1, input logic [1:0] r1, input logic [31:0] p0, input int w);
        l1_pte = p1; l1_resp = r1; l0_pte = p0; wait_n = w;
        nreads = 0; bad_addr = 0; unstable = 0;
    endtask

    task automatic capture();
        c_pf = resolve_pagefault; c_af = resolve_accessfault; c_tw = tlb_write;
        c_phys = resolve_physical_address; c_acc = resolve_access_bits;
        c_vaw = tlb_virtual_address_w; c_tag = tlb_accesstag_w; c_tphys = tlb_phys_w;
    endtask

    // Issues a request at a negedge and measures cycles until resolve_done (-1 on timeout).
    task automatic run_walk(input logic [19:0] vpn, input bit glitch, input bit hold, output int l);
        @(negedge clk);
        resolve_request = 1'b1;
        resolve_virtual_address = vpn;
        l = -1;
        for (int c = 1; c <= 60; c++) begin
            @(negedge clk);
            if (!hold) resolve_request = 1'b0;
            if (glitch && c == 1) begin
                satp_ppn = 22'h3FFFFF;
                resolve_virtual_address = ~vpn;
            end
            if (resolve_done) begin
                l = c;
                capture();
                break;
            end
        end
        if (glitch) satp_ppn = 22'h00100;
    endtask

    // Responder: completes each read after wait_n wait cycles, checks address stability.
    initial begin
        mif.m_transaction_done = 1'b0;
        mif.m_transaction_response = 2'd0;
        mif.m_rdata = 32'd0;
        forever begin
            @(negedge clk);
            if (rst || !mif.m_transaction) begin
                mif.m_transaction_done = 1'b0;
                wcnt = 0;
            end else begin
                if (mif.m_transaction_done) wcnt = 0;
                if (wcnt == 0) start_addr = mif.m_address;
                else if (mif.m_address !== start_addr) unstable++;
                if (wcnt >= wait_n) begin
                    mif.m_transaction_done = 1'b1;
                    nreads++;
                    if (mif.m_address === l1_addr) begin
                        mif.m_rdata = l1_pte; mif.m_transaction_response = l1_resp;
                    end else if (mif.m_address === l0_addr) begin
                        mif.m_rdata = l0_pte; mif.m_transaction_response = 2'd0;
                    end else begin
                        mif.m_rdata = 32'd0; mif.m_transaction_response = 2'd3;
                        bad_addr++;
                    end
                end else begin
                    mif.m_transaction_done = 1'b0;
                    wcnt++;
                end
            end
        end
    end

    initial begin
        rst = 1'b1;
        satp_ppn = 22'h00100;
        resolve_request = 1'b0;
        resolve_virtual_address = 20'h0;
        l1_addr = 34'h0_0010_0120;
        l0_addr = 34'h0_0020_0D14;
        setup(32'h0008_0001, 2'd0, 32'h0EAF_34CF, 0);

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_done", resolve_done, 0);
        check("rst_tlbw", tlb_write, 0);
        check("rst_mtrans", mif.m_transaction, 0);
        check("rst_pf", resolve_pagefault, 0);
        check("rst_af", resolve_accessfault, 0);
        check("rst_phys", resolve_physical_address, 0);
        check("rst_acc", resolve_access_bits, 0);
        rst = 1'b0;

        // 4 KiB walk, zero-wait
        run_walk(20'h12345, 0, 0, lat);
        check("k4_lat", lat, 3);
        check("k4_tlbw", c_tw, 1);
        check("k4_phys", c_phys, 22'h3ABCD);
        check("k4_acc", c_acc, 8'hCF);
        check("k4_vaw", c_vaw, 20'h12345);
        check("k4_tag", c_tag, 8'hCF);
        check("k4_tphys", c_tphys, 22'h3ABCD);
        check("k4_pf", c_pf, 0);
        check("k4_af", c_af, 0);
        check("k4_reads", nreads, 2);
        check("k4_badaddr", bad_addr, 0);

        // Megapage
        setup(32'h0030_000B, 2'd0, 32'h0EAF_34CF, 0);
        run_walk(20'h12345, 0, 0, lat);
        check("mp_lat", lat, 2);
        check("mp_reads", nreads, 1);
        check("mp_phys", c_phys, 22'h00F45);
        check("mp_acc", c_acc, 8'h0B);
        check("mp_tlbw", c_tw, 1);

        // Invalid L1 PTE, fault holds afterwards
        setup(32'h0000_0000, 2'd0, 32'h0EAF_34CF, 0);
        run_walk(20'h12345, 0, 0, lat);
        check("inv_lat", lat, 2);
        check("inv_pf", c_pf, 1);
        check("inv_af", c_af, 0);
        check("inv_tlbw", c_tw, 0);
        @(negedge clk);
        check("inv_pf_hold", resolve_pagefault, 1);
        check("inv_done_1cyc", resolve_done, 0);

        // Misaligned megapage
        setup(32'h0030_040B, 2'd0, 32'h0EAF_34CF, 0);
        run_walk(20'h12345, 0, 0, lat);
        check("mis_pf", c_pf, 1);
        check("mis_tlbw", c_tw, 0);
        check("mis_reads", nreads, 1);

        // Pointer at level 0
        setup(32'h0008_0001, 2'd0, 32'h0008_0001, 0);
        run_walk(20'h12345, 0, 0, lat);
        check("ptr0_pf", c_pf, 1);
        check("ptr0_tlbw", c_tw, 0);
        check("ptr0_reads", nreads, 2);

        // Access fault on L1 read
        setup(32'h0008_0001, 2'b10, 32'h0EAF_34CF, 0);
        run_walk(20'h12345, 0, 0, lat);
        check("af_af", c_af, 1);
        check("af_pf", c_pf, 0);
        check("af_tlbw", c_tw, 0);
        check("af_reads", nreads, 1);

        // Wait states, satp/VPN change mid-walk, request held through DONE
        setup(32'h0008_0001, 2'd0, 32'h0EAF_34CF, 3);
        resolve_virtual_address = 20'h12345;
        run_walk(20'h12345, 1, 1, lat);
        check("ws_lat", lat, 9);
        check("ws_stable", unstable, 0);
        check("ws_badaddr", bad_addr, 0);
        check("ws_phys", c_phys, 22'h3ABCD);
        resolve_virtual_address = 20'h12345;
        @(negedge clk);
        check("hold_idle_busy", busy, 0);
        check("hold_idle_done", resolve_done, 0);
        @(negedge clk);
        check("hold_restart", mif.m_transaction, 1);
        resolve_request = 1'b0;
        lat2 = -1;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            if (resolve_done) begin
                lat2 = c;
                capture();
                break;
            end
        end
        check("ws2_lat", lat2, 8);
        check("ws2_phys", c_phys, 22'h3ABCD);
        check("ws2_reads", nreads, 4);

        // Reset during the L0 wait
        setup(32'h0008_0001, 2'd0, 32'h0EAF_34CF, 3);
        @(negedge clk);
        resolve_request = 1'b1;
        resolve_virtual_address = 20'h12345;
        @(negedge clk);
        resolve_request = 1'b0;
        seen = 0;
        for (int c = 0; c < 40; c++) begin
            if (mif.m_transaction && mif.m_address === l0_addr) begin
                seen = 1;
                break;
            end
            @(negedge clk);
        end
        check("mr_reached_l0", seen, 1);
        rst = 1'b1;
        @(negedge clk);
        check("mr_busy", busy, 0);
        check("mr_mtrans", mif.m_transaction, 0);
        rst = 1'b0;
        seen = 0;
        for (int c = 0; c < 15; c++) begin
            @(negedge clk);
            if (resolve_done) seen++;
        end
        check("mr_no_done", seen, 0);
        setup(32'h0008_0001, 2'd0, 32'h0EAF_34CF, 0);
        run_walk(20'h12345, 0, 0, lat);
        check("mr_fresh_lat", lat, 3);
        check("mr_fresh_phys", c_phys, 22'h3ABCD);
        check("mr_fresh_tlbw", c_tw, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
